muldiv_ctrl: RTL and testbench

//   Sequencing controller for the CPU's multiply/divide resource. Owns the HI/LO result registers.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/boothmul.sv | 28 ++
 rtl/div_step.sv | 23 ++
 rtl/muldiv_ctrl.sv | 140 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide controller.
package muldiv_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MUL_WAIT = 3'd1,
        DIV_RUN  = 3'd2,
        DIV_FIX  = 3'd3,
        DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/boothmul.sv
// Combinational radix-2 Booth multiplier: P = signed(Q) * signed(M).
module boothmul #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   Q,
    input  logic [DATA_WIDTH-1:0]   M,
    output logic [2*DATA_WIDTH-1:0] P
);

    logic [2*DATA_WIDTH-1:0] m_ext;
    logic [DATA_WIDTH:0]     q_ext;

    assign m_ext = {{DATA_WIDTH{M[DATA_WIDTH-1]}}, M};
    assign q_ext = {Q, 1'b0};

    // Each adjacent bit pair (q[i], q[i-1]) adds or subtracts M << i.
    always_comb begin
        P = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            case (q_ext[i +: 2])
                2'b01:   P = P + (m_ext << i);
                2'b10:   P = P - (m_ext << i);
                default: P = P;
            endcase
        end
    end

endmodule

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, restore if negative.
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH:0]   rem_in,
    input  logic [DATA_WIDTH-1:0] q_in,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH:0]   rem_out,
    output logic [DATA_WIDTH-1:0] q_out
);

    logic [DATA_WIDTH+1:0] trial;
    logic                  neg;

    assign trial = {rem_in, q_in[DATA_WIDTH-1]} - {2'b00, d};
    assign neg   = trial[DATA_WIDTH+1];

    always_comb begin
        rem_out = neg ? {rem_in[DATA_WIDTH-1:0], q_in[DATA_WIDTH-1]} : trial[DATA_WIDTH:0];
        q_out   = {q_in[DATA_WIDTH-2:0], ~neg};
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer owning HI/LO: single-shot Booth multiply and
// a DATA_WIDTH-cycle signed restoring divide with start/busy/done handshake.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MUL_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int CNT_MAX = (DATA_WIDTH > MUL_LAT) ? DATA_WIDTH : MUL_LAT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    busy_q, done_q, dbz_q;
    logic [DATA_WIDTH-1:0]   hi_q, lo_q;
    logic [DATA_WIDTH-1:0]   mul_a_q, mul_b_q;
    logic [DATA_WIDTH-1:0]   divisor_q, quo_q;
    logic [DATA_WIDTH:0]     rem_q;
    logic                    qneg_q, rneg_q;

    logic [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH:0]     rem_d;
    logic [DATA_WIDTH-1:0]   quo_d;

    boothmul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
        .Q (mul_a_q),
        .M (mul_b_q),
        .P (prod)
    );

    div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .rem_in  (rem_q),
        .q_in    (quo_q),
        .d       (divisor_q),
        .rem_out (rem_d),
        .q_out   (quo_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (start) begin
                        cnt_q <= '0;
                        if (op == OP_MUL) begin
                            mul_a_q <= a;
                            mul_b_q <= b;
                            busy_q  <= 1'b1;
                            state_q <= MUL_WAIT;
                        end else if (b == '0) begin
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            // Magnitudes are divided unsigned; signs are restored in DIV_FIX.
                            quo_q     <= a[DATA_WIDTH-1] ? '0 - a : a;
                            divisor_q <= b[DATA_WIDTH-1] ? '0 - b : b;
                            rem_q     <= '0;
                            qneg_q    <= a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
                            rneg_q    <= a[DATA_WIDTH-1];
                            busy_q    <= 1'b1;
                            state_q   <= DIV_RUN;
                        end
                    end
                end
                MUL_WAIT: begin
                    if (cnt_q == MUL_LAST) begin
                        {hi_q, lo_q} <= prod;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DIV_RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == DIV_LAST) begin
                        state_q <= DIV_FIX;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DIV_FIX: begin
                    lo_q    <= qneg_q ? '0 - quo_q : quo_q;
                    hi_q    <= rneg_q ? '0 - rem_q[DATA_WIDTH-1:0] : rem_q[DATA_WIDTH-1:0];
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: latency/arithmetic model plus directed literal checks.
module tb_muldiv_ctrl;

    localparam int W       = 32;
    localparam int MUL_LAT = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] a, b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_ctrl #(.DATA_WIDTH(W), .MUL_LAT(MUL_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    // Model: an accepted op keeps busy for a fixed number of cycles, then
    // presents its arithmetic result with a one-cycle done.
    bit           chk_en = 1'b0;
    bit           m_act, m_done, m_dbz;
    int           m_left;
    logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
    longint       la, lb, lq, lr, lp;

    always @(posedge clk) begin
        if (rst) begin
            m_act = 0; m_done = 0; m_dbz = 0; m_left = 0;
            m_hi = '0; m_lo = '0;
            chk_en = 1'b1;
        end else if (chk_en) begin
            m_done = 0;
            m_dbz  = 0;
            if (m_act) begin
                m_left--;
                if (m_left == 0) begin
                    m_act  = 0;
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                    m_done = 1;
                end
            end else if (start) begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
                if (op == 1'b0) begin
                    lp = la * lb;
                    {p_hi, p_lo} = lp;
                    m_act  = 1;
                    m_left = MUL_LAT;
                end else if (b == '0) begin
                    m_done = 1;
                    m_dbz  = 1;
                end else begin
                    lq = la / lb;
                    lr = la % lb;
                    p_lo   = lq[W-1:0];
                    p_hi   = lr[W-1:0];
                    m_act  = 1;
                    m_left = W + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if ({busy, done, div_by_zero, hi, lo} !== {m_act, m_done, m_dbz, m_hi, m_lo}) begin
                n_fail++;
                $display("FAIL model t=%0t got busy=%b done=%b dbz=%b hi=%h lo=%h want busy=%b done=%b dbz=%b hi=%h lo=%h",
                         $time, busy, done, div_by_zero, hi, lo, m_act, m_done, m_dbz, m_hi, m_lo);
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Issue one op and wait for done; b2b issues it in the current (DONE) cycle.
    task automatic do_op(input string name, input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int lat, input logic [W-1:0] eh, input logic [W-1:0] el,
                         input logic ez, input bit b2b);
        int n;
        if (!b2b) @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        n = 1;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, W'(n), W'(lat));
        check({name, "_hi"}, hi, eh);
        check({name, "_lo"}, lo, el);
        check({name, "_dbz"}, W'(div_by_zero), W'(ez));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", W'(busy), '0);
        check("reset_done", W'(done), '0);
        check("reset_hi", hi, '0);
        check("reset_lo", lo, '0);
        rst = 1'b0;

        // MUL with MUL_LAT=1: busy at cycle 1, done at cycle 2
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'd10; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        check("mul_busy_c1", W'(busy), 32'd1);
        @(negedge clk);
        check("mul_done_c2", W'(done), 32'd1);
        check("mul_10x5_hi", hi, 32'd0);
        check("mul_10x5_lo", lo, 32'd50);

        do_op("mul_10xm5", 1'b0, 32'd10, 32'hFFFF_FFFB, 2, 32'hFFFF_FFFF, 32'hFFFF_FFCE, 1'b0, 1'b0);
        do_op("mul_m10xm5", 1'b0, 32'hFFFF_FFF6, 32'hFFFF_FFFB, 2, 32'd0, 32'd50, 1'b0, 1'b0);
        do_op("div_100_7", 1'b1, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0, 1'b0);
        do_op("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 34, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 1'b0);
        do_op("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 34, 32'd2, 32'hFFFF_FFF2, 1'b0, 1'b0);
        do_op("div_100_7b", 1'b1, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0, 1'b0);
        do_op("div_by_zero", 1'b1, 32'd7, 32'd0, 1, 32'd2, 32'd14, 1'b1, 1'b0);

        // start during a running DIV is ignored
        @(negedge clk);
        start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        n = 6;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ignored_start_latency", W'(n), 32'd34);
        check("ignored_start_lo", lo, 32'd14);
        check("ignored_start_hi", hi, 32'd2);

        // reset aborts a DIV in flight
        @(negedge clk);
        start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", W'(busy), '0);
        check("abort_hi", hi, '0);
        check("abort_lo", lo, '0);
        rst = 1'b0;

        // back-to-back: MUL accepted in the DIV's DONE cycle
        do_op("b2b_div", 1'b1, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0, 1'b0);
        do_op("b2b_mul", 1'b0, 32'd2000, 32'd2000, 2, 32'd0, 32'd4000000, 1'b0, 1'b1);
        do_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
